uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL provide parameter: TIMEOUT_CYCLES, default 32, clk cycles allowed in WAIT_BUSY or WAIT_DONE before abort (compiled in with ARB_TIMEOUT_EN only).
REQ-002 SHALL provide port: clk  input  1  single clock, same clock as the uart_tx instance it drives (txclk).
REQ-003 SHALL provide port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL provide port: req0_valid  input  1  requester 0 (RX echo path) byte available.
REQ-005 SHALL provide port: req0_data  input  8  requester 0 byte.
REQ-006 SHALL provide port: req0_ready  output  1  requester 0 holding slot empty.
REQ-007 SHALL provide ports req1_valid/req1_data/req1_ready for requester 1 (status/upload path), with the same widths and meanings.
REQ-008 SHALL provide port: tx_start  output  1  one-cycle start pulse to uart_tx.
REQ-009 SHALL provide port: tx_data  output  8  byte to uart_tx, held stable from tx_start until tx_done.
REQ-010 SHALL provide port: tx_busy  input  1  uart_tx busy.
REQ-011 SHALL provide port: tx_done  input  1  uart_tx frame-complete pulse.
REQ-012 SHALL provide port: grant  output  2  one-hot owner of the transmitter (bit0 = req0, bit1 = req1), 2'b00 when idle.
REQ-013 SHALL provide port: err_timeout  output  1  one-cycle pulse on abort (ARB_TIMEOUT_EN only).

Function
REQ-014 SHALL accept a byte on requester n when reqn_valid and reqn_ready are both high at a rising edge, storing it in that requester's 1-byte holding register and setting the register's full flag.
REQ-015 SHALL drive reqn_ready = !fulln combinationally from the registered flag; a slot freed on cycle k SHALL NOT accept a new byte before cycle k+1.
REQ-016 SHALL implement FSM states IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-017 IDLE: if any full flag is set, SHALL select the owner and go to LOAD; both full -> the requester not served last (round-robin); one full -> that requester.
REQ-018 LOAD: SHALL assert tx_start for exactly one cycle, drive tx_data from the owner's holding register, set grant, and go to WAIT_BUSY.
REQ-019 WAIT_BUSY: SHALL go to WAIT_DONE on tx_busy=1, or directly to completion on tx_done=1.
REQ-020 WAIT_DONE: on tx_done=1, SHALL clear the owner's full flag, record the owner as last served, clear grant, and return to IDLE.
REQ-021 Latency: SHALL assert tx_start 2 cycles after acceptance into an empty arbiter (cycle 1 IDLE select, cycle 2 LOAD).
REQ-022 SHALL ignore tx_done outside WAIT_BUSY and WAIT_DONE.
REQ-023 SHALL NOT alter the owner's holding register while it is granted; the non-owner SHALL continue to accept bytes.
REQ-024 After completion, SHALL allow IDLE to grant the next byte without an idle gap beyond the single IDLE cycle.

Reset
REQ-025 On reset=0 at a rising edge, SHALL set: state=IDLE, full flags=0, last served=req1 (so req0 wins the first tie), tx_start=0, tx_data=8'h00, grant=2'b00, err_timeout=0.
REQ-026 Reset mid-frame SHALL discard both held bytes and any in-flight grant; reqn_ready SHALL read 1 on the first cycle after reset deasserts.

Configuration
REQ-027 Macro ARB_TIMEOUT_EN defined: a counter SHALL run in WAIT_BUSY/WAIT_DONE; on reaching TIMEOUT_CYCLES it SHALL pulse err_timeout, drop the owner's byte (clear its full flag), update last served, and return to IDLE.
REQ-028 Macro ARB_TIMEOUT_EN undefined: no counter SHALL exist, err_timeout SHALL be tied to 0, and the FSM SHALL wait indefinitely for tx_done.

Verification
REQ-029 Reset then req0 8'h55 alone; uart_tx model busy 10 cycles -> tx_start 2 cycles after accept, tx_data=8'h55, grant=2'b01, req0_ready low until tx_done.
REQ-030 req0 8'hA1 and req1 8'hB2 accepted on the same edge -> A1 sent first, then B2; grant sequence 01,00,10,00.
REQ-031 Both requesters valid continuously with bytes 8'h10.. and 8'h20.. -> strict alternation 10,20,11,21,... with no starvation over 8 frames.
REQ-032 req1 byte sent while req0 pushes 8'h3C mid-frame -> 3C accepted during the req1 frame, sent next; req1 held byte unchanged.
REQ-033 reset=0 asserted during WAIT_DONE with both slots full -> all outputs at reset values the next cycle, no tx_start afterwards until new valid.
REQ-034 ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=32, tx_done never returned -> err_timeout pulses 32 cycles after entering WAIT_BUSY, slot freed, the next requester is granted; with the macro undefined the FSM stays in WAIT_DONE.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one uart_tx between two byte sources (req0: RX echo, req1: status
// upload). Each source has a one-byte holding slot; the slots are served
// round-robin when both are full.
//
// Optional feature: define ARB_TIMEOUT_EN to compile in an abort timer that
// releases the transmitter when uart_tx never returns tx_done. Without the
// macro there is no timer, err_timeout is tied low and the arbiter waits for
// tx_done indefinitely.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no frame owned; pick an owner if any holding slot is full
// LOAD      | pulse tx_start, present the owner's byte, raise grant
// WAIT_BUSY | frame launched, waiting for uart_tx to report busy
// WAIT_DONE | uart_tx busy, waiting for tx_done to free the owner's slot
module uart_tx_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic [1:0] grant,
    output logic       err_timeout
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;

    // Holding slots, one per requester.
    logic       full0;
    logic       full1;
    logic [7:0] hold0;
    logic [7:0] hold1;

    // owner / last_served encode the requester index: 0 = req0, 1 = req1.
    logic       owner;
    logic       last_served;
    logic       sel_any;
    logic       sel_owner;

    logic       complete;
    logic       abort;
    logic       release_slot;

    // A slot never accepts while full, so a slot being released can only
    // take a new byte on the following edge.
    assign req0_ready = !full0;
    assign req1_ready = !full1;

    assign sel_any = full0 | full1;

    // Tie goes to whoever was not served last; otherwise the only full slot.
    assign sel_owner = (full0 && full1) ? ~last_served : full1;

    assign release_slot = complete | abort;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic            in_wait;
    logic [TO_W-1:0] to_cnt;

    assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);

    // A real tx_done on the terminal cycle wins over the abort.
    assign abort = in_wait && (to_cnt == '0) && !tx_done;

    // Down-counter armed in LOAD; reaches zero on the TIMEOUT_CYCLES-th
    // edge spent in the wait states.
    always_ff @(posedge clk) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (state == LOAD) begin
            to_cnt <= TO_LOAD;
        end else if (in_wait && (to_cnt != '0)) begin
            to_cnt <= to_cnt - 1'b1;
        end
    end

    // One-cycle abort indication.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= abort;
        end
    end
`else
    logic unused_timeout_cfg;

    assign abort              = 1'b0;
    assign err_timeout        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Next-state decode; tx_done is only honoured in the two wait states.
    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (sel_any) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_done) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // State register, owner capture in IDLE, round-robin history on release.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && sel_any) begin
                owner <= sel_owner;
            end
            if (release_slot) begin
                last_served <= owner;
            end
        end
    end

    // Requester 0 slot: load on handshake, empty when its frame is released.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full0 <= 1'b0;
            hold0 <= 8'h00;
        end else if (req0_valid && req0_ready) begin
            full0 <= 1'b1;
            hold0 <= req0_data;
        end else if (release_slot && (owner == 1'b0)) begin
            full0 <= 1'b0;
        end
    end

    // Requester 1 slot: load on handshake, empty when its frame is released.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full1 <= 1'b0;
            hold1 <= 8'h00;
        end else if (req1_valid && req1_ready) begin
            full1 <= 1'b1;
            hold1 <= req1_data;
        end else if (release_slot && (owner == 1'b1)) begin
            full1 <= 1'b0;
        end
    end

    // Transmitter-side outputs: start pulse and byte launched from LOAD,
    // grant held until the frame is released. tx_data keeps its last value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            grant    <= 2'b00;
        end else begin
            tx_start <= (state == LOAD);
            if (state == LOAD) begin
                tx_data <= owner ? hold1 : hold0;
                grant   <= owner ? 2'b10 : 2'b01;
            end else if (release_slot) begin
                grant <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios, a small uart_tx responder,
// and a time-based reference model compared against the DUT every cycle.
module tb_uart_tx_arbiter;

    localparam int TIMEOUT  = 32;
    localparam int BUSY_LEN = 10;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data  = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data  = 8'h00;
    logic       req1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy    = 1'b0;
    logic       tx_done    = 1'b0;
    logic [1:0] grant;
    logic       err_timeout;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant       (grant),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: slot contents plus the edge count since an owner was
    // picked. Start lands one edge after the pick, completion on any later
    // tx_done, abort TIMEOUT edges after the start.
    int         cyc       = 0;
    bit         m_ok      = 1'b0;
    bit         m_full [2];
    logic [7:0] m_hold [2];
    int         m_last    = 1;
    int         m_owner   = -1;
    int         m_sel_cyc = 0;
    logic [7:0] m_txdata  = 8'h00;
    bit         m_start   = 1'b0;
    logic [1:0] m_grant   = 2'b00;
    bit         m_err     = 1'b0;

    always @(posedge clk) begin
        bit f0;
        bit f1;
        int age;
        cyc++;
        f0 = m_full[0];
        f1 = m_full[1];
        if (!reset) begin
            m_ok      = 1'b1;
            m_full[0] = 1'b0;
            m_full[1] = 1'b0;
            m_last    = 1;
            m_owner   = -1;
            m_txdata  = 8'h00;
            m_start   = 1'b0;
            m_grant   = 2'b00;
            m_err     = 1'b0;
        end else begin
            m_start = 1'b0;
            m_err   = 1'b0;
            if (m_owner < 0) begin
                if (f0 || f1) begin
                    m_owner   = (f0 && f1) ? (1 - m_last) : (f0 ? 0 : 1);
                    m_sel_cyc = cyc;
                end
            end else begin
                age = cyc - m_sel_cyc;
                if (age == 1) begin
                    m_start  = 1'b1;
                    m_txdata = m_hold[m_owner];
                    m_grant  = (m_owner == 0) ? 2'b01 : 2'b10;
                end else if (tx_done || (TO_EN && age == 1 + TIMEOUT)) begin
                    m_err           = !tx_done;
                    m_full[m_owner] = 1'b0;
                    m_last          = m_owner;
                    m_grant         = 2'b00;
                    m_owner         = -1;
                end
            end
            if (req0_valid && !f0) begin
                m_full[0] = 1'b1;
                m_hold[0] = req0_data;
            end
            if (req1_valid && !f1) begin
                m_full[1] = 1'b1;
                m_hold[1] = req1_data;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            check("req0_ready",  32'(req0_ready),  32'(!m_full[0]));
            check("req1_ready",  32'(req1_ready),  32'(!m_full[1]));
            check("tx_start",    32'(tx_start),    32'(m_start));
            check("tx_data",     32'(tx_data),     32'(m_txdata));
            check("grant",       32'(grant),       32'(m_grant));
            check("err_timeout", 32'(err_timeout), 32'(m_err));
        end
    end

    // uart_tx responder: busy for BUSY_LEN cycles then a one-cycle tx_done.
    bit         uart_hang = 1'b0;
    bit         u_run     = 1'b0;
    int         u_cnt     = 0;
    logic [7:0] u_lat     = 8'h00;
    logic [7:0] sent_q [$];
    logic [1:0] grant_q [$];

    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!reset) begin
            u_run   = 1'b0;
            tx_busy = 1'b0;
        end else if (tx_start === 1'b1) begin
            u_run   = 1'b1;
            tx_busy = 1'b1;
            u_cnt   = BUSY_LEN;
            u_lat   = tx_data;
            sent_q.push_back(tx_data);
            grant_q.push_back(grant);
        end else if (u_run && !uart_hang) begin
            u_cnt--;
            if (u_cnt == 0) begin
                u_run   = 1'b0;
                tx_busy = 1'b0;
                tx_done = 1'b1;
                check("tx_data_stable", 32'(tx_data), 32'(u_lat));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset      = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        sent_q.delete();
        grant_q.delete();
    endtask

    task automatic push(input bit v0, input logic [7:0] d0, input bit v1, input logic [7:0] d1);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_start(input string name, output int n);
        n = 0;
        while (tx_start !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check(name, 32'(tx_start), 1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (grant !== 2'b00 && k < 200) begin
            step();
            k++;
        end
        check(name, 32'(grant), 0);
    endtask

    task automatic wait_sent(input string name, input int n);
        int k;
        k = 0;
        while (sent_q.size() < n && k < 600) begin
            step();
            k++;
        end
        check(name, sent_q.size(), n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int d0;
        int d1;
        int cnt;
        bit p0;
        bit p1;

        // Reset values
        step();
        step();
        check("rst_req0_ready",  32'(req0_ready),  1);
        check("rst_req1_ready",  32'(req1_ready),  1);
        check("rst_grant",       32'(grant),       0);
        check("rst_tx_data",     32'(tx_data),     0);
        check("rst_tx_start",    32'(tx_start),    0);
        check("rst_err_timeout", 32'(err_timeout), 0);
        reset = 1'b1;
        step();

        // Single byte on req0
        push(1'b1, 8'h55, 1'b0, 8'h00);
        wait_start("s1_start", n);
        check("s1_latency",    n, 2);
        check("s1_tx_data",    32'(tx_data), 'h55);
        check("s1_grant",      32'(grant), 'b01);
        check("s1_req0_ready", 32'(req0_ready), 0);
        wait_idle("s1_idle");
        check("s1_ready_after", 32'(req0_ready), 1);

        // Simultaneous bytes: req0 first after reset
        do_reset();
        push(1'b1, 8'hA1, 1'b1, 8'hB2);
        wait_sent("s2_sent", 2);
        wait_idle("s2_idle");
        check("s2_byte0",  32'(sent_q[0]),  'hA1);
        check("s2_byte1",  32'(sent_q[1]),  'hB2);
        check("s2_grant0", 32'(grant_q[0]), 'b01);
        check("s2_grant1", 32'(grant_q[1]), 'b10);

        // Continuous traffic from both: strict alternation
        do_reset();
        d0 = 0;
        d1 = 0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 8'h10;
        req1_data  = 8'h20;
        k = 0;
        while ((req0_valid || req1_valid) && k < 600) begin
            p0 = req0_valid && req0_ready;
            p1 = req1_valid && req1_ready;
            step();
            k++;
            if (p0) begin
                d0++;
                if (d0 == 4) req0_valid = 1'b0;
                else req0_data = 8'(8'h10 + d0);
            end
            if (p1) begin
                d1++;
                if (d1 == 4) req1_valid = 1'b0;
                else req1_data = 8'(8'h20 + d1);
            end
        end
        wait_sent("s3_sent", 8);
        wait_idle("s3_idle");
        for (int i = 0; i < 8; i++) begin
            check($sformatf("s3_byte%0d", i), 32'(sent_q[i]),
                  (i % 2 == 0) ? ('h10 + i / 2) : ('h20 + i / 2));
        end

        // req0 pushes mid-frame while req1 owns the transmitter
        do_reset();
        push(1'b0, 8'h00, 1'b1, 8'h7E);
        wait_start("s4_start", n);
        check("s4_grant", 32'(grant), 'b10);
        push(1'b1, 8'h3C, 1'b0, 8'h00);
        check("s4_req0_taken", 32'(req0_ready), 0);
        check("s4_grant_held", 32'(grant), 'b10);
        req1_valid = 1'b1;
        req1_data  = 8'hEE;
        step();
        step();
        step();
        check("s4_req1_blocked", 32'(req1_ready), 0);
        check("s4_tx_data_held", 32'(tx_data), 'h7E);
        k  = 0;
        p1 = 1'b0;
        while (k < 200) begin
            p1 = req1_ready;
            step();
            k++;
            if (p1) break;
        end
        req1_valid = 1'b0;
        check("s4_ee_accept", 32'(p1), 1);
        wait_sent("s4_sent", 3);
        wait_idle("s4_idle");
        check("s4_byte0", 32'(sent_q[0]), 'h7E);
        check("s4_byte1", 32'(sent_q[1]), 'h3C);
        check("s4_byte2", 32'(sent_q[2]), 'hEE);

        // Reset in WAIT_DONE with both slots full
        do_reset();
        push(1'b1, 8'hC5, 1'b1, 8'hD6);
        wait_start("s5_start", n);
        step();
        step();
        step();
        check("s5_req0_full", 32'(req0_ready), 0);
        check("s5_req1_full", 32'(req1_ready), 0);
        check("s5_grant",     32'(grant), 'b01);
        reset = 1'b0;
        step();
        check("s5_rst_req0_ready", 32'(req0_ready),  1);
        check("s5_rst_req1_ready", 32'(req1_ready),  1);
        check("s5_rst_grant",      32'(grant),       0);
        check("s5_rst_tx_start",   32'(tx_start),    0);
        check("s5_rst_tx_data",    32'(tx_data),     0);
        check("s5_rst_err",        32'(err_timeout), 0);
        reset = 1'b1;
        step();
        check("s5_post_req0_ready", 32'(req0_ready), 1);
        check("s5_post_req1_ready", 32'(req1_ready), 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (tx_start === 1'b1) cnt++;
        end
        check("s5_no_restart", cnt, 0);

        // tx_done never returned
        do_reset();
        uart_hang = 1'b1;
        push(1'b1, 8'h91, 1'b1, 8'h92);
        wait_start("s6_start", n);
        check("s6_grant", 32'(grant), 'b01);
`ifdef ARB_TIMEOUT_EN
        n = 0;
        while (err_timeout !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("s6_timeout_cycles", n, TIMEOUT);
        check("s6_slot_freed",     32'(req0_ready), 1);
        check("s6_grant_cleared",  32'(grant), 0);
        wait_start("s6_next_start", n);
        check("s6_next_data",  32'(tx_data), 'h92);
        check("s6_next_grant", 32'(grant), 'b10);
`else
        for (int i = 0; i < 40; i++) step();
        check("s6_grant_held", 32'(grant), 'b01);
        check("s6_no_err",     32'(err_timeout), 0);
        check("s6_slot_held",  32'(req0_ready), 0);
        check("s6_no_start",   32'(tx_start), 0);
`endif
        uart_hang = 1'b0;
        do_reset();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
